// File: rtl/dnn2ami_req_arbiter.sv
// Two-source (read/write) arbiter in front of one AMI request port.
// Burst-limited ownership with a one-entry registered output slot.
`ifndef AMI_REQUEST_BUS_WIDTH
`define AMI_REQUEST_BUS_WIDTH 512
`endif

module dnn2ami_req_arbiter #(
  parameter int REQ_W     = `AMI_REQUEST_BUS_WIDTH,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_reqValid,
  input  logic [REQ_W-1:0] rd_reqOut,
  output logic             rd_grant,
  input  logic             wr_reqValid,
  input  logic [REQ_W-1:0] wr_reqOut,
  output logic             wr_grant,
  output logic             mem_reqValid,
  output logic [REQ_W-1:0] mem_reqOut,
  input  logic             mem_grant,
  output logic [CNT_W-1:0] rd_issued,
  output logic [CNT_W-1:0] wr_issued,
  output logic             arb_idle
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic       OWN_RD  = 1'b0;
  localparam logic       OWN_WR  = 1'b1;
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  logic             out_valid_q, out_valid_d;
  logic [REQ_W-1:0] out_data_q, out_data_d;
  logic [1:0]       state_q, state_d;
  logic [7:0]       burst_q, burst_d, burst_inc;
  logic             last_q, last_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             slot_free;
  logic             pick_rd, pick_wr;
  logic             gnt_rd, gnt_wr;

  // Gating with rst_n keeps grants low for the whole reset window.
  assign slot_free = rst_n && (!out_valid_q || mem_grant);
  assign burst_inc = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + 8'd1;

  always_comb begin
    pick_rd = 1'b0;
    pick_wr = 1'b0;
    if (rd_reqValid && !wr_reqValid) begin
      pick_rd = 1'b1;
    end else if (!rd_reqValid && wr_reqValid) begin
      pick_wr = 1'b1;
    end else if (rd_reqValid && wr_reqValid) begin
      case (state_q)
        ST_RD: begin
          if (burst_q < BURST_MAX) pick_rd = 1'b1;
          else                     pick_wr = 1'b1;
        end
        ST_WR: begin
          if (burst_q < BURST_MAX) pick_wr = 1'b1;
          else                     pick_rd = 1'b1;
        end
        default: begin
          // Fresh tie goes to whoever did not own the port last.
          if (last_q == OWN_WR) pick_rd = 1'b1;
          else                  pick_wr = 1'b1;
        end
      endcase
    end
  end

  assign gnt_rd = slot_free && pick_rd;
  assign gnt_wr = slot_free && pick_wr;

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (slot_free) begin
      out_valid_d = gnt_rd || gnt_wr;
      if (gnt_rd) begin
        state_d    = ST_RD;
        last_d     = OWN_RD;
        burst_d    = (state_q == ST_RD) ? burst_inc : 8'd1;
        out_data_d = rd_reqOut;
      end else if (gnt_wr) begin
        state_d    = ST_WR;
        last_d     = OWN_WR;
        burst_d    = (state_q == ST_WR) ? burst_inc : 8'd1;
        out_data_d = wr_reqOut;
      end else begin
        state_d = ST_IDLE;
        burst_d = 8'd0;
      end
    end
  end

  assign rd_cnt_d = rd_cnt_q + CNT_W'(gnt_rd);
  assign wr_cnt_d = wr_cnt_q + CNT_W'(gnt_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      state_q     <= ST_IDLE;
      burst_q     <= 8'd0;
      last_q      <= OWN_WR;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      state_q     <= state_d;
      burst_q     <= burst_d;
      last_q      <= last_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign rd_grant     = gnt_rd;
  assign wr_grant     = gnt_wr;
  assign mem_reqValid = out_valid_q;
  assign mem_reqOut   = out_data_q;
  assign rd_issued    = rd_cnt_q;
  assign wr_issued    = wr_cnt_q;
  assign arb_idle     = !out_valid_q && !rd_reqValid && !wr_reqValid;

endmodule
